io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised multi-channel device I/O bank between the processor's control/datapath and external devices (switches, buttons, displays). It replaces the fixed 4×32-bit `dev_in`/`dev_out` and `enter_in`/`enter_out` wiring. New behaviour:
- per-channel input FIFOs, filled on synchronised `enter_in` strobes;
- a request/ready read handshake, with a channel select, for the processor's input instruction;
- channel-addressed output writes;
- a generated `wake_up` level;
- sticky overflow flags.

## Interface
Parameters:
- `CH`, 4, number of device channels (≥1)
- `W`, 32, data width per channel
- `DEPTH`, 4, entries per input FIFO (power of 2, ≥2)

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `dev_in`  in  CH*W  device data; channel i occupies bits [i*W +: W]
- `enter_in`  in  CH  device strobes; asynchronous, level held by the device
- `in_req`  in  1  processor read request; held high until `in_ready`
- `in_ch`  in  max(1,$clog2(CH))  read channel select
- `in_ready`  out  1  one-cycle read acknowledge; `in_data` is valid in the same cycle
- `in_data`  out  W  read data
- `out_req`  in  1  one-cycle output write strobe
- `out_ch`  in  max(1,$clog2(CH))  write channel select
- `out_data`  in  W  write data
- `dev_out`  out  CH*W  registered device outputs; channel i occupies bits [i*W +: W]
- `enter_out`  out  CH  one-cycle "new output" pulse per channel
- `wake_up`  out  1  high while any input FIFO is non-empty
- `overflow`  out  CH  sticky per-channel "push dropped" flag
- `ovf_clr`  in  1  clears all `overflow` bits

## Operation
- Input capture, per channel i:
  - `enter_in[i]` passes through a 2-flop synchroniser, then rising-edge detection against a previous-value flop.
  - On a detected edge, the current `dev_in` slice is pushed into FIFO i.
- Sync and previous-value flops reset to 0. An `enter_in[i]` already high at reset release therefore produces exactly one push.
- Full FIFO:
  - A push is accepted if a pop of the same channel occurs in the same cycle.
  - Otherwise the push is dropped (contents unchanged) and `overflow[i]` is set.
- `overflow` clearing: `ovf_clr` clears all bits. A same-cycle set beats the clear.
- Read FSM, states IDLE, WAIT, ACK:
  - IDLE & `in_req`: register `in_ch`.
    - Selected FIFO non-empty → ACK: pop it, load `in_data`.
    - FIFO empty → WAIT.
    - `in_ch`≥CH → ACK with `in_data`=0 and no pop.
  - WAIT: `in_req` low → IDLE (abort, no pop). Registered FIFO non-empty → ACK with pop.
  - ACK: `in_ready`=1 → IDLE unconditionally. `in_req` is not re-sampled in ACK.
- Output write: `out_req` with `out_ch`<CH writes `out_data` to the `dev_out` slice and pulses `enter_out[out_ch]` for one cycle. `out_ch`≥CH is ignored.
- `wake_up` is registered: OR of all non-empty flags.
- Reset values:
  - `in_ready`, `in_data`, `dev_out`, `enter_out`, `wake_up`, `overflow` all 0.
  - FIFOs empty; FSM in IDLE.
- Reset mid-handshake returns to IDLE. An in-flight pop completed before reset is lost.

## Timing
- Input path, with e0 = first edge that samples `enter_in[i]`=1:
  - push at edge e0+2;
  - `dev_in` slice sampled at e0+2 (device holds data ≥3 cycles);
  - `wake_up` high after e0+3.
- Read, non-empty FIFO: `in_req` sampled at edge r0 → `in_ready`/`in_data` valid in the cycle after r0. Next request is sampled no earlier than r0+2.
- Read, empty FIFO: `in_ready` appears 1 cycle after the edge where FIFO i becomes non-empty.
- Output: `out_req` at edge w0 → `dev_out` slice and `enter_out` pulse visible after w0, for exactly one cycle of pulse.
- Back-to-back `out_req` on the same channel yields back-to-back pulses, i.e. `enter_out[i]` stays high.

## Structure
- Package `io_pkg`:
  - read FSM state enum (IDLE, WAIT, ACK);
  - channel-index width function max(1,$clog2(n)).
- Sub-module `io_fifo`:
  - synchronous FIFO, parameters W and DEPTH;
  - ports: push, pop, wdata, rdata, full, empty;
  - ptr+1 wrap pointers; same-cycle push/pop legal;
  - instantiated CH times in a generate loop.
- Synchroniser, edge detect, FSM, and output registers live in `io_port_bank`.

## Test plan
- Reset with `enter_in`=0 → all outputs 0. Raise `enter_in[2]` with `dev_in` ch2=32'hA5 → `wake_up` high at e0+3. Then `in_req`,`in_ch`=2 → `in_ready` one cycle, `in_data`=32'hA5, `wake_up` falls.
- `in_req`,`in_ch`=1 with FIFO 1 empty for 10 cycles → `in_ready` stays 0. Then strobe ch1 with 7 → `in_ready` with `in_data`=7.
- 5 strobes on ch0 (values 1..5), DEPTH=4 → `overflow[0]`=1. Four reads return 1,2,3,4. `ovf_clr` → 0.
- Full FIFO: push and pop on the same cycle → push accepted, no overflow, count stays 4.
- `out_req`,`out_ch`=3,`out_data`=32'hDEAD → `dev_out[127:96]`=32'hDEAD, `enter_out`=4'b1000 for one cycle. `out_ch`=5 with CH=4 → no change.
- Assert `rst` while in WAIT and during an ACK cycle → FSM IDLE, `in_ready`=0, FIFOs empty, `overflow`=0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and helpers for the device I/O bank.
package io_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_ACK  = 2'd2
    } rd_state_t;

    // Channel-index width; a single channel still needs a 1-bit select.
    function automatic int unsigned ch_w(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module io_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// Multi-channel device I/O bank: synchronised input capture into per-channel
// FIFOs, a request/ready read handshake, and channel-addressed output writes.
module io_port_bank
    import io_pkg::*;
#(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*W-1:0]      dev_in,
    input  logic [CH-1:0]        enter_in,
    input  logic                 in_req,
    input  logic [ch_w(CH)-1:0]  in_ch,
    output logic                 in_ready,
    output logic [W-1:0]         in_data,
    input  logic                 out_req,
    input  logic [ch_w(CH)-1:0]  out_ch,
    input  logic [W-1:0]         out_data,
    output logic [CH*W-1:0]      dev_out,
    output logic [CH-1:0]        enter_out,
    output logic                 wake_up,
    output logic [CH-1:0]        overflow,
    input  logic                 ovf_clr
);
    localparam int unsigned CW = ch_w(CH);

    logic [CH-1:0]   r_sync1;
    logic [CH-1:0]   r_sync2;
    logic [CH-1:0]   r_prev;
    logic [CH-1:0]   w_edge;
    logic [CH-1:0]   w_full;
    logic [CH-1:0]   w_empty;
    logic [CH-1:0]   w_pop;
    logic [CH-1:0]   w_ovf_set;
    logic [W-1:0]    w_rdata [CH];

    rd_state_t       r_state;
    rd_state_t       w_state_nxt;
    logic [CW-1:0]   r_ch;
    logic [CW-1:0]   w_ch_nxt;
    logic            r_in_ready;
    logic            w_in_ready_nxt;
    logic [W-1:0]    r_in_data;
    logic [W-1:0]    w_in_data_nxt;
    logic            w_pop_en;
    logic [CW-1:0]   w_pop_ch;

    logic            w_req_valid;
    logic            w_req_empty;
    logic [W-1:0]    w_req_data;
    logic            w_wait_empty;
    logic [W-1:0]    w_wait_data;

    logic [CH*W-1:0] r_dev_out;
    logic [CH-1:0]   r_enter_out;
    logic            r_wake_up;
    logic [CH-1:0]   r_overflow;

    // Input strobe synchroniser and rising-edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= enter_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        io_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_edge[gi]),
            .pop   (w_pop[gi]),
            .wdata (dev_in[gi*W +: W]),
            .rdata (w_rdata[gi]),
            .full  (w_full[gi]),
            .empty (w_empty[gi])
        );
    end

    // Look up FIFO status for the requested and the latched channel.
    always_comb begin
        w_req_valid  = 1'b0;
        w_req_empty  = 1'b1;
        w_req_data   = '0;
        w_wait_empty = 1'b1;
        w_wait_data  = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == CW'(i)) begin
                w_req_valid = 1'b1;
                w_req_empty = w_empty[i];
                w_req_data  = w_rdata[i];
            end
            if (r_ch == CW'(i)) begin
                w_wait_empty = w_empty[i];
                w_wait_data  = w_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RD_IDLE;
            r_ch       <= '0;
            r_in_ready <= 1'b0;
            r_in_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ch       <= w_ch_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_in_data  <= w_in_data_nxt;
        end
    end

    // Read handshake; an out-of-range channel is acknowledged with zero data.
    always_comb begin
        w_state_nxt    = r_state;
        w_ch_nxt       = r_ch;
        w_in_ready_nxt = 1'b0;
        w_in_data_nxt  = r_in_data;
        w_pop_en       = 1'b0;
        w_pop_ch       = r_ch;
        case (r_state)
            RD_IDLE: begin
                if (in_req) begin
                    w_ch_nxt = in_ch;
                    if (!w_req_valid) begin
                        w_state_nxt    = RD_ACK;
                        w_in_ready_nxt = 1'b1;
                        w_in_data_nxt  = '0;
                    end else if (!w_req_empty) begin
                        w_state_nxt    = RD_ACK;
                        w_in_ready_nxt = 1'b1;
                        w_in_data_nxt  = w_req_data;
                        w_pop_en       = 1'b1;
                        w_pop_ch       = in_ch;
                    end else begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!in_req) begin
                    w_state_nxt = RD_IDLE;
                end else if (!w_wait_empty) begin
                    w_state_nxt    = RD_ACK;
                    w_in_ready_nxt = 1'b1;
                    w_in_data_nxt  = w_wait_data;
                    w_pop_en       = 1'b1;
                    w_pop_ch       = r_ch;
                end
            end
            RD_ACK: begin
                w_state_nxt = RD_IDLE;
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop[i] = w_pop_en && (w_pop_ch == CW'(i));
        end
    end

    // A push is dropped only when the FIFO is full and not popped this cycle.
    assign w_ovf_set = w_edge & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dev_out   <= '0;
            r_enter_out <= '0;
            r_wake_up   <= 1'b0;
            r_overflow  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_enter_out[i] <= out_req && (out_ch == CW'(i));
                if (out_req && (out_ch == CW'(i))) begin
                    r_dev_out[i*W +: W] <= out_data;
                end
            end
            r_wake_up  <= |(~w_empty);
            r_overflow <= (r_overflow & ~{CH{ovf_clr}}) | w_ovf_set;
        end
    end

    assign in_ready  = r_in_ready;
    assign in_data   = r_in_data;
    assign dev_out   = r_dev_out;
    assign enter_out = r_enter_out;
    assign wake_up   = r_wake_up;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (CH=4 main instance, CH=3 for out-of-range).
module tb_io_port_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] dev_in;
    logic [3:0]   enter_in;
    logic         in_req;
    logic [1:0]   in_ch;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_req;
    logic [1:0]   out_ch;
    logic [31:0]  out_data;
    logic [127:0] dev_out;
    logic [3:0]   enter_out;
    logic         wake_up;
    logic [3:0]   overflow;
    logic         ovf_clr;

    logic [95:0]  dev_in3;
    logic [2:0]   enter_in3;
    logic         in_req3;
    logic [1:0]   in_ch3;
    logic         in_ready3;
    logic [31:0]  in_data3;
    logic         out_req3;
    logic [1:0]   out_ch3;
    logic [31:0]  out_data3;
    logic [95:0]  dev_out3;
    logic [2:0]   enter_out3;
    logic         wake_up3;
    logic [2:0]   overflow3;
    logic         ovf_clr3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_port_bank #(.CH(4), .W(32), .DEPTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .dev_in    (dev_in),
        .enter_in  (enter_in),
        .in_req    (in_req),
        .in_ch     (in_ch),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .dev_out   (dev_out),
        .enter_out (enter_out),
        .wake_up   (wake_up),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    io_port_bank #(.CH(3), .W(32), .DEPTH(4)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .dev_in    (dev_in3),
        .enter_in  (enter_in3),
        .in_req    (in_req3),
        .in_ch     (in_ch3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_req   (out_req3),
        .out_ch    (out_ch3),
        .out_data  (out_data3),
        .dev_out   (dev_out3),
        .enter_out (enter_out3),
        .wake_up   (wake_up3),
        .overflow  (overflow3),
        .ovf_clr   (ovf_clr3)
    );

    // One device strobe: hold data and enter high 3 cycles, then low 3 cycles.
    task automatic strobe(input int ch, input logic [31:0] val);
        dev_in[ch*32 +: 32] = val;
        enter_in[ch] = 1'b1;
        repeat (3) @(negedge clk);
        enter_in[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Bounded read request; returns whether in_ready was seen and the data.
    task automatic read_ch(input logic [1:0] ch, input int max_cyc,
                           output logic got, output logic [31:0] data);
        got  = 1'b0;
        data = '0;
        in_req = 1'b1;
        in_ch  = ch;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got  = 1'b1;
                data = in_data;
                break;
            end
        end
        in_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dev_in = '0; enter_in = '0; in_req = 1'b0; in_ch = '0;
        out_req = 1'b0; out_ch = '0; out_data = '0; ovf_clr = 1'b0;
        dev_in3 = '0; enter_in3 = '0; in_req3 = 1'b0; in_ch3 = '0;
        out_req3 = 1'b0; out_ch3 = '0; out_data3 = '0; ovf_clr3 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0h exp 0", in_ready); end
        checks++; if (in_data !== 32'h0) begin errors++; $display("FAIL reset_in_data: got %0h exp 0", in_data); end
        checks++; if (dev_out !== 128'h0) begin errors++; $display("FAIL reset_dev_out: got %0h exp 0", dev_out); end
        checks++; if (enter_out !== 4'h0) begin errors++; $display("FAIL reset_enter_out: got %0h exp 0", enter_out); end
        checks++; if (wake_up !== 1'b0) begin errors++; $display("FAIL reset_wake_up: got %0h exp 0", wake_up); end
        checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL reset_overflow: got %0h exp 0", overflow); end
    endtask

    task automatic test_wake_read();
        dev_in[95:64] = 32'hA5;
        enter_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wake_up !== 1'b0) begin errors++; $display("FAIL wake_early: got %0h exp 0", wake_up); end
        enter_in[2] = 1'b0;
        @(negedge clk);
        checks++; if (wake_up !== 1'b1) begin errors++; $display("FAIL wake_e0p3: got %0h exp 1", wake_up); end
        in_req = 1'b1;
        in_ch  = 2'd2;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rd2_ready: got %0h exp 1", in_ready); end
        checks++; if (in_data !== 32'hA5) begin errors++; $display("FAIL rd2_data: got %0h exp a5", in_data); end
        in_req = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rd2_ready_pulse: got %0h exp 0", in_ready); end
        checks++; if (wake_up !== 1'b0) begin errors++; $display("FAIL wake_fall: got %0h exp 0", wake_up); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wait_read();
        logic       bad;
        logic [3:0] rdy;
        logic [31:0] d;
        bad = 1'b0;
        in_req = 1'b1;
        in_ch  = 2'd1;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wait_no_ready: got %0h exp 0", bad); end
        dev_in[63:32] = 32'd7;
        enter_in[1] = 1'b1;
        rdy = '0;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rdy[k] = in_ready;
            if (k == 3) d = in_data;
        end
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL wait_ready_timing: got %b exp 1000", rdy); end
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL wait_data: got %0h exp 7", d); end
        in_req = 1'b0;
        enter_in[1] = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_ready_pulse: got %0h exp 0", in_ready); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic        got;
        logic [31:0] d;
        for (int v = 1; v <= 4; v++) strobe(0, 32'(v));
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_at_full: got %b exp 0000", overflow); end
        strobe(0, 32'd5);
        checks++; if (overflow !== 4'b0001) begin errors++; $display("FAIL ovf_set: got %b exp 0001", overflow); end
        for (int v = 1; v <= 4; v++) begin
            read_ch(2'd0, 4, got, d);
            checks++;
            if (got !== 1'b1 || d !== 32'(v)) begin
                errors++; $display("FAIL ovf_read%0d: got ready=%0h data=%0h exp ready=1 data=%0h", v, got, d, v);
            end
        end
        read_ch(2'd0, 4, got, d);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got ready=%0h data=%0h exp ready=0", got, d); end
        checks++; if (overflow !== 4'b0001) begin errors++; $display("FAIL ovf_sticky: got %b exp 0001", overflow); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b exp 0000", overflow); end
    endtask

    task automatic test_full_pushpop();
        logic        got;
        logic [31:0] d;
        for (int v = 0; v < 4; v++) strobe(3, 32'h10 + 32'(v));
        dev_in[127:96] = 32'h14;
        enter_in[3] = 1'b1;
        repeat (2) @(negedge clk);
        in_req = 1'b1;
        in_ch  = 2'd3;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || in_data !== 32'h10) begin
            errors++; $display("FAIL pp_read: got ready=%0h data=%0h exp ready=1 data=10", in_ready, in_data);
        end
        in_req = 1'b0;
        enter_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL pp_no_ovf: got %b exp 0000", overflow); end
        for (int v = 1; v <= 4; v++) begin
            read_ch(2'd3, 4, got, d);
            checks++;
            if (got !== 1'b1 || d !== 32'h10 + 32'(v)) begin
                errors++; $display("FAIL pp_read%0d: got ready=%0h data=%0h exp ready=1 data=%0h", v, got, d, 32'h10 + 32'(v));
            end
        end
        read_ch(2'd3, 4, got, d);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL pp_count: got ready=%0h exp 0", got); end
    endtask

    task automatic test_output();
        out_req = 1'b1; out_ch = 2'd3; out_data = 32'hDEAD;
        @(negedge clk);
        out_req = 1'b0;
        checks++; if (dev_out !== {32'hDEAD, 96'h0}) begin errors++; $display("FAIL out3_data: got %0h exp dead<<96", dev_out); end
        checks++; if (enter_out !== 4'b1000) begin errors++; $display("FAIL out3_pulse: got %b exp 1000", enter_out); end
        @(negedge clk);
        checks++; if (enter_out !== 4'b0000) begin errors++; $display("FAIL out3_pulse_end: got %b exp 0000", enter_out); end
        out_req = 1'b1; out_ch = 2'd0; out_data = 32'h1;
        @(negedge clk);
        checks++; if (enter_out !== 4'b0001 || dev_out[31:0] !== 32'h1) begin
            errors++; $display("FAIL b2b_first: got pulse=%b data=%0h exp 0001/1", enter_out, dev_out[31:0]);
        end
        out_data = 32'h2;
        @(negedge clk);
        out_req = 1'b0;
        checks++; if (enter_out !== 4'b0001 || dev_out[31:0] !== 32'h2) begin
            errors++; $display("FAIL b2b_second: got pulse=%b data=%0h exp 0001/2", enter_out, dev_out[31:0]);
        end
        @(negedge clk);
        checks++; if (enter_out !== 4'b0000 || dev_out !== {32'hDEAD, 64'h0, 32'h2}) begin
            errors++; $display("FAIL b2b_end: got pulse=%b dev_out=%0h", enter_out, dev_out);
        end
    endtask

    task automatic test_out_of_range();
        out_req3 = 1'b1; out_ch3 = 2'd2; out_data3 = 32'h55;
        @(negedge clk);
        out_ch3 = 2'd3; out_data3 = 32'h99;
        @(negedge clk);
        out_req3 = 1'b0;
        checks++; if (enter_out3 !== 3'b000 || dev_out3 !== {32'h55, 64'h0}) begin
            errors++; $display("FAIL oor_write: got pulse=%b dev_out=%0h exp 000/55<<64", enter_out3, dev_out3);
        end
        in_req3 = 1'b1; in_ch3 = 2'd3;
        @(negedge clk);
        in_req3 = 1'b0;
        checks++; if (in_ready3 !== 1'b1 || in_data3 !== 32'h0) begin
            errors++; $display("FAIL oor_read: got ready=%0h data=%0h exp 1/0", in_ready3, in_data3);
        end
        @(negedge clk);
        checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL oor_read_pulse: got %0h exp 0", in_ready3); end
    endtask

    task automatic test_reset_mid();
        logic        got;
        logic [31:0] d;
        for (int v = 0; v < 5; v++) strobe(2, 32'h20 + 32'(v));
        checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL rm_pre_ovf: got %b exp 0100", overflow); end
        in_req = 1'b1; in_ch = 2'd1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (overflow !== 4'b0000 || wake_up !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rm_wait_async: got ovf=%b wake=%0h ready=%0h exp 0/0/0", overflow, wake_up, in_ready);
        end
        in_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wake_up !== 1'b0 || overflow !== 4'b0000) begin
            errors++; $display("FAIL rm_wait_after: got wake=%0h ovf=%b exp 0/0000", wake_up, overflow);
        end
        read_ch(2'd2, 4, got, d);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL rm_fifo_empty: got ready=%0h data=%0h exp ready=0", got, d); end
        strobe(2, 32'h9);
        in_req = 1'b1; in_ch = 2'd2;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || in_data !== 32'h9) begin
            errors++; $display("FAIL rm_ack_pre: got ready=%0h data=%0h exp 1/9", in_ready, in_data);
        end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || in_data !== 32'h0) begin
            errors++; $display("FAIL rm_ack_async: got ready=%0h data=%0h exp 0/0", in_ready, in_data);
        end
        in_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || wake_up !== 1'b0) begin
            errors++; $display("FAIL rm_ack_after: got ready=%0h wake=%0h exp 0/0", in_ready, wake_up);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wake_read();
        test_wait_read();
        test_overflow();
        test_full_pushpop();
        test_output();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
